// File: rtl/code_sequencer.sv
// Code-line sequencer: a small program store that steps a PC through
// lines 0..end_line and presents each code word to a consumer.
module code_sequencer #(
  parameter int unsigned CODE_SIZE = 12,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned ADDR_W    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 advance,
  input  logic                 jump,
  input  logic [ADDR_W-1:0]    jump_addr,
  input  logic [ADDR_W-1:0]    end_line,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CODE_SIZE-1:0] wr_data,
  output logic [CODE_SIZE-1:0] code,
  output logic                 code_valid,
  output logic [ADDR_W-1:0]    code_index,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          exec_count
);

  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastLine = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StError} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [CODE_SIZE-1:0]  mem_q [DEPTH];

  logic [ADDR_W-1:0]     eff_end;
  logic                  run_active;
  logic                  wr_en;

  // An end_line beyond the store is treated as the last physical line.
  assign eff_end    = ({1'b0, end_line} >= DepthExt) ? LastLine : end_line;
  assign run_active = enable && (state_q == StRun);
  assign wr_ready   = enable && (state_q != StRun);
  assign wr_en      = wr_valid && wr_ready && ({1'b0, wr_addr} < DepthExt);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (enable) begin
      unique case (state_q)
        StRun: begin
          if (advance) begin
            cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
            if (jump) begin
              if (jump_addr > eff_end) begin
                state_d = StError;
              end else begin
                pc_d = jump_addr;
              end
            end else if (pc_q >= eff_end) begin
              // >= also catches end_line being lowered below pc mid-run.
              state_d = StDone;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            state_d = StRun;
            pc_d    = '0;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Program store is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    code       = '0;
    code_index = '0;
    if (run_active) begin
      code       = mem_q[pc_q];
      code_index = pc_q;
    end
  end

  assign code_valid = run_active;
  assign done       = (state_q == StDone);
  assign error      = (state_q == StError);
  assign exec_count = cnt_q;

endmodule

// File: tb/tb_code_sequencer.sv
// Table-driven bench for code_sequencer with a scoreboard queue of expected outputs.
module tb_code_sequencer;

  localparam int unsigned CS = 12;
  localparam int unsigned DP = 100;
  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          reset, enable, start, advance, jump;
  logic [AW-1:0] jump_addr, end_line, wr_addr, code_index;
  logic          wr_valid, wr_ready, code_valid, done, error;
  logic [CS-1:0] wr_data, code;
  logic [31:0]   exec_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  code_sequencer #(.CODE_SIZE(CS), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .advance    (advance),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .end_line   (end_line),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .code       (code),
    .code_valid (code_valid),
    .code_index (code_index),
    .done       (done),
    .error      (error),
    .exec_count (exec_count)
  );

  typedef struct {
    int unsigned en, st, adv, jmp, ja, el, wv, wa, wd;
    int unsigned code, cv, idx, dn, er, cnt, wrdy;
  } vec_t;

  typedef struct {
    string       tag;
    int unsigned code, cv, idx, dn, er, cnt, wrdy;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk({e.tag, " code"},       32'(code),       e.code);
    chk({e.tag, " code_valid"}, 32'(code_valid), e.cv);
    chk({e.tag, " code_index"}, 32'(code_index), e.idx);
    chk({e.tag, " done"},       32'(done),       e.dn);
    chk({e.tag, " error"},      32'(error),      e.er);
    chk({e.tag, " exec_count"}, exec_count,      e.cnt);
    chk({e.tag, " wr_ready"},   32'(wr_ready),   e.wrdy);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    enable    = v.en[0];
    start     = v.st[0];
    advance   = v.adv[0];
    jump      = v.jmp[0];
    jump_addr = v.ja[AW-1:0];
    end_line  = v.el[AW-1:0];
    wr_valid  = v.wv[0];
    wr_addr   = v.wa[AW-1:0];
    wr_data   = v.wd[CS-1:0];
    e = '{tag, v.code, v.cv, v.idx, v.dn, v.er, v.cnt, v.wrdy};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_outputs(sb.pop_front());
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; advance = 1'b0; jump = 1'b0;
    jump_addr = '0; end_line = 7'd3; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs('{"reset", 0, 0, 0, 0, 0, 0, 1});
    @(negedge clk);
    reset = 1'b0;

    //        en st ad jp ja  el  wv wa   wd      code    cv idx dn er cnt wrdy
    vq.push_back('{1, 0, 0, 0, 0,  3,  1, 0,   'h001,  0,      0, 0,  0, 0, 0, 1});
    vq.push_back('{1, 0, 0, 0, 0,  3,  1, 1,   'h002,  0,      0, 0,  0, 0, 0, 1});
    vq.push_back('{1, 0, 0, 0, 0,  3,  1, 2,   'h003,  0,      0, 0,  0, 0, 0, 1});
    vq.push_back('{1, 0, 0, 0, 0,  3,  1, 3,   'h004,  0,      0, 0,  0, 0, 0, 1});
    vq.push_back('{1, 0, 0, 0, 0,  3,  1, 99,  'h0F0,  0,      0, 0,  0, 0, 0, 1});
    vq.push_back('{1, 0, 0, 0, 0,  3,  1, 120, 'h555,  0,      0, 0,  0, 0, 0, 1});
    vq.push_back('{1, 1, 0, 0, 0,  3,  0, 0,   0,      'h001,  1, 0,  0, 0, 0, 0});
    vq.push_back('{1, 0, 1, 0, 0,  3,  0, 0,   0,      'h002,  1, 1,  0, 0, 1, 0});
    vq.push_back('{1, 0, 1, 0, 0,  3,  0, 0,   0,      'h003,  1, 2,  0, 0, 2, 0});
    vq.push_back('{1, 0, 1, 0, 0,  3,  0, 0,   0,      'h004,  1, 3,  0, 0, 3, 0});
    vq.push_back('{1, 0, 1, 0, 0,  3,  0, 0,   0,      0,      0, 0,  1, 0, 4, 1});
    vq.push_back('{1, 0, 1, 0, 0,  3,  0, 0,   0,      0,      0, 0,  1, 0, 4, 1});
    vq.push_back('{1, 1, 0, 0, 0,  3,  0, 0,   0,      'h001,  1, 0,  0, 0, 0, 0});
    vq.push_back('{1, 0, 1, 0, 0,  3,  0, 0,   0,      'h002,  1, 1,  0, 0, 1, 0});
    vq.push_back('{1, 0, 0, 1, 0,  3,  0, 0,   0,      'h002,  1, 1,  0, 0, 1, 0});
    vq.push_back('{1, 0, 1, 1, 0,  3,  0, 0,   0,      'h001,  1, 0,  0, 0, 2, 0});
    vq.push_back('{1, 1, 0, 0, 0,  3,  0, 0,   0,      'h001,  1, 0,  0, 0, 2, 0});
    vq.push_back('{1, 0, 1, 1, 5,  3,  0, 0,   0,      0,      0, 0,  0, 1, 3, 1});
    vq.push_back('{1, 1, 0, 0, 0,  3,  0, 0,   0,      'h001,  1, 0,  0, 0, 0, 0});
    vq.push_back('{1, 0, 1, 0, 0,  3,  0, 0,   0,      'h002,  1, 1,  0, 0, 1, 0});
    vq.push_back('{0, 0, 1, 0, 0,  3,  0, 0,   0,      0,      0, 0,  0, 0, 1, 0});
    vq.push_back('{0, 0, 1, 0, 0,  3,  0, 0,   0,      0,      0, 0,  0, 0, 1, 0});
    vq.push_back('{0, 0, 1, 0, 0,  3,  0, 0,   0,      0,      0, 0,  0, 0, 1, 0});
    vq.push_back('{1, 0, 0, 0, 0,  3,  0, 0,   0,      'h002,  1, 1,  0, 0, 1, 0});
    vq.push_back('{1, 0, 1, 1, 99, 127, 0, 0,  0,      'h0F0,  1, 99, 0, 0, 2, 0});
    vq.push_back('{1, 0, 1, 0, 0,  127, 0, 0,  0,      0,      0, 0,  1, 0, 3, 1});
    vq.push_back('{0, 0, 0, 0, 0,  3,  0, 0,   0,      0,      0, 0,  1, 0, 3, 0});
    vq.push_back('{1, 1, 0, 0, 0,  3,  1, 0,   'hABC,  'hABC,  1, 0,  0, 0, 0, 0});
    vq.push_back('{1, 0, 1, 0, 0,  3,  1, 1,   'hFFF,  'h002,  1, 1,  0, 0, 1, 0});
    vq.push_back('{1, 0, 1, 0, 0,  3,  0, 0,   0,      'h003,  1, 2,  0, 0, 2, 0});

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // Asynchronous reset between edges while running at pc=2.
    #2;
    reset = 1'b1;
    #1;
    check_outputs('{"async_reset", 0, 0, 0, 0, 0, 0, 1});
    @(negedge clk);
    reset = 1'b0;
    apply('{1, 0, 0, 0, 0, 3, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1}, "post_reset_idle");
    apply('{1, 1, 0, 0, 0, 3, 0, 0, 0, 'hABC, 1, 0, 0, 0, 0, 0}, "post_reset_start");
    apply('{1, 0, 1, 0, 0, 3, 0, 0, 0, 'h002, 1, 1, 0, 0, 1, 0}, "post_reset_adv");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
